// File: rtl/y_wave_pkg.sv
// Shared definitions for the Y-wave capture controller: bank geometry, FSM states,
// trigger modes and the level-crossing rule.
package y_wave_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TRIG_FREE = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_RSVD = 2'd3
    } trig_mode_e;

    typedef struct packed {
        trig_mode_e    mode;
        logic [DW-1:0] level;
        logic [DW-1:0] decim;
    } cap_cfg_t;

    // Edge modes compare against the previous sample; free-run (and reserved) fire at once.
    function automatic logic needs_prev(trig_mode_e mode);
        return (mode == TRIG_RISE) || (mode == TRIG_FALL);
    endfunction

    function automatic logic trig_hit(trig_mode_e mode, logic [DW-1:0] level,
                                      logic [DW-1:0] prev, logic [DW-1:0] cur);
        case (mode)
            TRIG_RISE: return (prev < level) && (cur >= level);
            TRIG_FALL: return (prev > level) && (cur <= level);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/y_wave_capture_ctrl_if.sv
// Sample stream, capture configuration and drawer RAM port of the capture controller.
interface y_wave_capture_ctrl_if;
    import y_wave_pkg::*;

    logic          enable;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [1:0]    trig_mode;
    logic [DW-1:0] trig_level;
    logic [DW-1:0] decim;
    logic          frame_sync;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [DW-1:0] ram_rddata;
    logic          bank_sel;
    logic          capture_done;
    logic          forced_trig;

    modport slave (
        input  enable, s_valid, s_data, trig_mode, trig_level, decim,
               frame_sync, ram_addr, ram_rd,
        output s_ready, ram_rddata, bank_sel, capture_done, forced_trig
    );

    modport master (
        output enable, s_valid, s_data, trig_mode, trig_level, decim,
               frame_sync, ram_addr, ram_rd,
        input  s_ready, ram_rddata, bank_sel, capture_done, forced_trig
    );

endinterface

// File: rtl/y_wave_bank_ram.sv
// Ping-pong waveform store: 2*DEPTH x DW simple dual-port RAM addressed by {bank, addr},
// synchronous write, registered read that holds when not reading.
module y_wave_bank_ram
    import y_wave_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW:0]   raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2*DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the storage array is deliberately left out of reset so it maps onto block RAM;
    // only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/y_wave_capture_ctrl.sv
// Y-wave capture controller: triggered, decimated fill of the hidden bank, handed to the
// drawer only on frame_sync so a frame is never drawn from a half-written bank.
module y_wave_capture_ctrl
    import y_wave_pkg::*;
#(
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    y_wave_capture_ctrl_if.slave bus
);

    localparam logic [15:0] TO_LAST = 16'(AUTO_TIMEOUT - 1);
    localparam bit          TO_EN   = (AUTO_TIMEOUT != 0);

    state_e        state_q, state_d;
    cap_cfg_t      cfg_q, cfg_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    dec_cnt_q, dec_cnt_d;
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic          forced_q, forced_d;
    logic          bank_sel_q, bank_sel_d;
    logic          done_q, done_d;
    logic          forced_trig_q, forced_trig_d;

    logic          s_ready;
    logic          accept;
    logic          hit;
    logic          timeout;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] rd_data;

    assign s_ready = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign accept  = bus.s_valid && s_ready;
    assign hit     = trig_hit(cfg_q.mode, cfg_q.level, prev_q, bus.s_data)
                     && (have_prev_q || !needs_prev(cfg_q.mode));
    assign timeout = TO_EN && (to_cnt_q == TO_LAST);

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cfg_d         = cfg_q;
        wr_addr_d     = wr_addr_q;
        dec_cnt_d     = dec_cnt_q;
        to_cnt_d      = to_cnt_q;
        prev_d        = prev_q;
        have_prev_d   = have_prev_q;
        forced_d      = forced_q;
        bank_sel_d    = bank_sel_q;
        done_d        = 1'b0;
        forced_trig_d = forced_trig_q;
        we            = 1'b0;
        waddr         = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                cfg_d       = '{mode: trig_mode_e'(bus.trig_mode), level: bus.trig_level,
                                decim: bus.decim};
                to_cnt_d    = '0;
                have_prev_d = 1'b0;
                if (bus.enable) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    prev_d      = bus.s_data;
                    have_prev_d = 1'b1;
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                    if (hit || timeout) begin
                        we        = 1'b1;
                        waddr     = '0;
                        wr_addr_d = AW'(1);
                        dec_cnt_d = cfg_q.decim;
                        forced_d  = !hit;
                        state_d   = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (dec_cnt_q == '0) begin
                        we        = 1'b1;
                        wr_addr_d = wr_addr_q + AW'(1);
                        dec_cnt_d = cfg_q.decim;
                        if (&wr_addr_q) begin
                            state_d = ST_FULL;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q - 8'd1;
                    end
                end
            end

            ST_FULL: begin
                to_cnt_d    = '0;
                have_prev_d = 1'b0;
                if (bus.frame_sync) begin
                    bank_sel_d    = !bank_sel_q;
                    done_d        = 1'b1;
                    forced_trig_d = forced_q;
                    state_d       = bus.enable ? ST_ARM : ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            wr_addr_q     <= '0;
            dec_cnt_q     <= '0;
            to_cnt_q      <= '0;
            prev_q        <= '0;
            have_prev_q   <= 1'b0;
            forced_q      <= 1'b0;
            bank_sel_q    <= 1'b0;
            done_q        <= 1'b0;
            forced_trig_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            wr_addr_q     <= wr_addr_d;
            dec_cnt_q     <= dec_cnt_d;
            to_cnt_q      <= to_cnt_d;
            prev_q        <= prev_d;
            have_prev_q   <= have_prev_d;
            forced_q      <= forced_d;
            bank_sel_q    <= bank_sel_d;
            done_q        <= done_d;
            forced_trig_q <= forced_trig_d;
        end
    end

    // Writes always land in the hidden bank; a reset cycle never touches the RAM.
    y_wave_bank_ram u_bank_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we && !rst),
        .waddr_i ({!bank_sel_q, waddr}),
        .wdata_i (bus.s_data),
        .re_i    (bus.ram_rd),
        .raddr_i ({bank_sel_q, bus.ram_addr}),
        .rdata_o (rd_data)
    );

    assign bus.s_ready      = s_ready;
    assign bus.ram_rddata   = rd_data;
    assign bus.bank_sel     = bank_sel_q;
    assign bus.capture_done = done_q;
    assign bus.forced_trig  = forced_trig_q;

endmodule

// File: tb/tb_y_wave_capture_ctrl.sv
// Randomized bench for y_wave_capture_ctrl against a sample-list reference model
// that derives trigger point, decimated bank contents and swap timing from the capture rules.
module tb_y_wave_capture_ctrl;
    import y_wave_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y_wave_capture_ctrl_if bus ();

    y_wave_capture_ctrl #(.AUTO_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_COLLECT, M_FULL} mphase_e;

    mphase_e m_phase;
    int      acc[$];
    int      trig_idx;
    bit      trig_forced;
    int      c_mode, c_level, c_decim;
    int      bank_mem[2][256];
    bit      bank_known[2];
    bit      m_bank_sel, m_done, m_forced_trig;
    int      m_rddata;
    bit      m_rd_known;
    int      swaps;

    function automatic bit rule_hit(int mode, int lvl, int prev, int cur);
        case (mode)
            1:       return (prev < lvl) && (cur >= lvl);
            2:       return (prev > lvl) && (cur <= lvl);
            default: return 1'b1;
        endcase
    endfunction

    task automatic start_collect();
        acc.delete();
        trig_idx = -1;
        bank_known[m_bank_sel ? 0 : 1] = 1'b0;
        m_phase = M_COLLECT;
    endtask

    task automatic model_update();
        int n;
        int wb;
        m_done = 1'b0;
        if (rst) begin
            m_phase       = M_IDLE;
            m_bank_sel    = 1'b0;
            m_forced_trig = 1'b0;
            m_rddata      = 0;
            m_rd_known    = 1'b1;
            return;
        end
        if (bus.ram_rd) begin
            m_rddata   = bank_mem[m_bank_sel ? 1 : 0][int'(bus.ram_addr)];
            m_rd_known = bank_known[m_bank_sel ? 1 : 0];
        end
        case (m_phase)
            M_IDLE: begin
                if (bus.enable) begin
                    c_mode  = int'(bus.trig_mode);
                    c_level = int'(bus.trig_level);
                    c_decim = int'(bus.decim);
                    start_collect();
                end
            end
            M_COLLECT: begin
                if (!bus.enable) begin
                    m_phase = M_IDLE;
                end else if (bus.s_valid) begin
                    n = acc.size();
                    acc.push_back(int'(bus.s_data));
                    if (trig_idx < 0) begin
                        if (c_mode == 0 || c_mode == 3 ||
                            (n > 0 && rule_hit(c_mode, c_level, acc[n-1], acc[n]))) begin
                            trig_idx    = n;
                            trig_forced = 1'b0;
                        end else if (TO != 0 && n == TO - 1) begin
                            trig_idx    = n;
                            trig_forced = 1'b1;
                        end
                    end
                    if (trig_idx >= 0 && n - trig_idx == 255 * (c_decim + 1)) begin
                        wb = m_bank_sel ? 0 : 1;
                        for (int k = 0; k < 256; k++) begin
                            bank_mem[wb][k] = acc[trig_idx + k * (c_decim + 1)];
                        end
                        bank_known[wb] = 1'b1;
                        m_phase = M_FULL;
                    end
                end
            end
            default: begin
                if (bus.frame_sync) begin
                    m_bank_sel    = !m_bank_sel;
                    m_done        = 1'b1;
                    m_forced_trig = trig_forced;
                    swaps++;
                    if (bus.enable) start_collect();
                    else            m_phase = M_IDLE;
                end
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    int unsigned sine_tab[16] = '{128, 166, 199, 220, 228, 220, 199, 166,
                                  128,  90,  57,  36,  28,  36,  57,  90};
    int valid_pct, src, const_val, fs_period, rd_pct, fs_cnt, done_seen;
    bit fs_on_last;

    // Inputs are set at the falling edge; outputs are compared at the next falling edge.
    task automatic step();
        check("s_ready", bus.s_ready, (m_phase == M_COLLECT) ? 1 : 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (bus.capture_done === 1'b1) done_seen++;
        check("bank_sel", bus.bank_sel, m_bank_sel);
        check("capture_done", bus.capture_done, m_done);
        check("forced_trig", bus.forced_trig, m_forced_trig);
        if (m_rd_known) check("ram_rddata", bus.ram_rddata, m_rddata);
    endtask

    task automatic cycle();
        int  idx;
        bit  noswap;
        bit  saved;
        idx = acc.size();
        bus.s_valid = ($urandom_range(0, 99) < valid_pct);
        case (src)
            0:       bus.s_data = idx[7:0];
            1:       bus.s_data = sine_tab[(idx + 10) % 16][7:0];
            2:       bus.s_data = const_val[7:0];
            default: bus.s_data = $urandom_range(0, 255);
        endcase
        fs_cnt++;
        bus.frame_sync = (fs_period > 0) && (fs_cnt % fs_period == 0);
        noswap = 1'b0;
        saved  = m_bank_sel;
        if (fs_on_last && m_phase == M_COLLECT && bus.enable && bus.s_valid && trig_idx >= 0
            && idx - trig_idx == 255 * (c_decim + 1)) begin
            bus.frame_sync = 1'b1;
            fs_on_last     = 1'b0;
            noswap         = 1'b1;
        end
        bus.ram_rd   = ($urandom_range(0, 99) < rd_pct);
        bus.ram_addr = $urandom_range(0, 255);
        step();
        if (noswap) begin
            check("fs_on_last_bank_sel", bus.bank_sel, saved);
            check("fs_on_last_done", bus.capture_done, 0);
        end
    endtask

    task automatic idle(input int n);
        bus.enable     = 1'b0;
        bus.s_valid    = 1'b0;
        bus.frame_sync = 1'b0;
        bus.ram_rd     = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd_check(input int addr, input int exp, input string tag);
        bus.ram_rd     = 1'b1;
        bus.ram_addr   = addr[7:0];
        bus.s_valid    = 1'b0;
        bus.frame_sync = 1'b0;
        step();
        bus.ram_rd     = 1'b0;
        check(tag, bus.ram_rddata, exp);
    endtask

    task automatic start(input int mode, input int lvl, input int dec);
        bus.trig_mode  = mode[1:0];
        bus.trig_level = lvl[7:0];
        bus.decim      = dec[7:0];
        bus.enable     = 1'b1;
        fs_cnt         = 0;
    endtask

    task automatic run_until_swap(input int budget, input string tag);
        int target;
        int c;
        target = swaps + 1;
        c = 0;
        while (swaps < target && c < budget) begin
            cycle();
            c++;
        end
        check(tag, (swaps >= target) ? 1 : 0, 1);
    endtask

    task automatic run_until_written(input int count, input int budget, input string tag);
        int c;
        c = 0;
        while (!(m_phase == M_COLLECT && trig_idx >= 0 && acc.size() - trig_idx == count)
               && c < budget) begin
            cycle();
            c++;
        end
        check(tag, (c < budget) ? 1 : 0, 1);
    endtask

    initial begin
        bit saved_sel;
        rst = 1'b1;
        bus.enable = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.trig_mode = '0;
        bus.trig_level = '0; bus.decim = '0; bus.frame_sync = 1'b0; bus.ram_addr = '0;
        bus.ram_rd = 1'b0;
        valid_pct = 100; src = 0; const_val = 0; fs_period = 0; rd_pct = 0; fs_cnt = 0;
        fs_on_last = 1'b0; done_seen = 0; swaps = 0; trig_idx = -1; trig_forced = 1'b0;
        bank_known[0] = 1'b0; bank_known[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_phase = M_IDLE; m_bank_sel = 1'b0; m_done = 1'b0; m_forced_trig = 1'b0;
        m_rddata = 0; m_rd_known = 1'b1;

        // Reset state
        step();
        rst = 1'b0;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_rddata", bus.ram_rddata, 0);
        check("rst_bank_sel", bus.bank_sel, 0);
        idle(2);

        // 1: free-run ramp, decim 0, frame_sync every 300 cycles
        done_seen = 0; valid_pct = 100; src = 0; fs_period = 300; rd_pct = 30;
        start(0, 0, 0);
        run_until_swap(2000, "t1_swap");
        check("t1_done_once", done_seen, 1);
        check("t1_bank_sel", bus.bank_sel, 1);
        idle(2);
        for (int k = 0; k < 256; k++) rd_check(k, k, "t1_ramp_read");

        // 2: rising at 128 on a sine
        valid_pct = 70; src = 1; fs_period = 50; rd_pct = 40;
        start(1, 128, 0);
        run_until_swap(3000, "t2_swap");
        idle(2);
        rd_check(0, 128, "t2_addr0");
        rd_check(1, 166, "t2_addr1");
        check("t2_forced", bus.forced_trig, 0);

        // 3: rising at 200 on constant 10 -> timeout-forced trigger
        valid_pct = 80; src = 2; const_val = 10; fs_period = 70;
        start(1, 200, 0);
        run_until_swap(3000, "t3_swap");
        check("t3_forced", bus.forced_trig, 1);
        idle(2);
        rd_check(0, 10, "t3_addr0");

        // 4: decim 3 on a ramp
        valid_pct = 90; src = 0; fs_period = 100;
        start(0, 0, 3);
        run_until_swap(6000, "t4_swap");
        idle(2);
        rd_check(1, 4, "t4_addr1");
        rd_check(255, 252, "t4_addr255");

        // 5: frame_sync coinciding with the last write is ignored
        valid_pct = 85; src = 3; fs_period = 64; rd_pct = 60; fs_on_last = 1'b1;
        start(0, 0, 0);
        run_until_swap(3000, "t5_swap");
        check("t5_fs_last_seen", fs_on_last ? 0 : 1, 1);
        fs_on_last = 1'b0;
        idle(2);

        // 6a: enable dropped mid-capture at wr_addr 100
        valid_pct = 100; src = 0; fs_period = 0; rd_pct = 0;
        saved_sel = m_bank_sel;
        start(0, 0, 0);
        run_until_written(100, 500, "t6a_reach");
        bus.enable = 1'b0;
        bus.s_valid = 1'b0;
        step();
        check("t6a_ready", bus.s_ready, 0);
        check("t6a_bank_sel", bus.bank_sel, saved_sel);
        for (int k = 0; k < 4; k++) rd_check(k * 85, bank_mem[saved_sel ? 1 : 0][k * 85], "t6a_display");

        // 6b: reset at wr_addr 100, with bank 0 on display so bank_sel is unchanged by reset
        if (m_bank_sel) begin
            fs_period = 40;
            start(0, 0, 0);
            run_until_swap(2000, "t6b_align");
            idle(2);
            fs_period = 0;
        end
        start(0, 0, 0);
        run_until_written(100, 500, "t6b_reach");
        rst = 1'b1;
        bus.s_valid = 1'b0;
        step();
        rst = 1'b0;
        bus.enable = 1'b0;
        check("t6b_ready", bus.s_ready, 0);
        check("t6b_bank_sel", bus.bank_sel, 0);
        rd_check(100, bank_mem[0][100], "t6b_display");
        rd_check(7, bank_mem[0][7], "t6b_display");

        // Randomized captures
        for (int i = 0; i < 6; i++) begin
            valid_pct = $urandom_range(50, 100);
            src       = $urandom_range(0, 3);
            const_val = $urandom_range(0, 255);
            fs_period = $urandom_range(20, 200);
            rd_pct    = 50;
            start($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 3));
            run_until_swap(8000, "rand_swap");
            idle($urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
